fifo_pattern_checker: RTL
=========================

# fifo_pattern_checker

Read-side engine of the FIFO loopback test. It drains the FIFO, checks each word against the incrementing ASCII pattern the write side produces (BASE, BASE+1, …), and reports pass/fail plus first-error diagnostics to status outputs and the board LEDs. It sits on the FIFO read port in the read clock domain and replaces the hand-written read state machine in the top level.

## Interface
Parameters:
- NDATA, 18: words expected per test run (1..2047).
- BASE, 65: value of the first expected word; word k expects (BASE+k) mod 256.
- RD_LAT, 1: cycles from a sampled fifo_rd_en to valid fifo_q (1..3).
- TIMEOUT, 1024: idle-cycle limit, used only with CHK_TIMEOUT_EN.

Ports:
- CLOCK, in, 1: single clock, the FIFO read clock.
- RESET_N, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse that begins a run.
- fifo_empty, in, 1: FIFO Empty flag.
- fifo_q, in, 8: FIFO read data.
- fifo_rd_en, out, 1: FIFO RdEn.
- busy, out, 1: high while a run is in progress.
- pass, out, 1: sticky; all NDATA words matched.
- fail, out, 1: sticky; mismatch or timeout.
- timeout, out, 1: sticky; the failure was a timeout. Tied 0 when CHK_TIMEOUT_EN is undefined.
- rcv_cnt, out, 11: number of words compared so far.
- err_idx, out, 11: index of the first mismatching word.
- err_data, out, 8: fifo_q value at the first mismatch.
- led_r_n, out, 1: active-low; equals !fail.
- led_g_n, out, 1: active-low; equals !pass.
- led_b_n, out, 1: active-low; equals !busy.

## Operation
- States:
  - IDLE: waits for start. Clears counters, pass, fail and timeout, then moves to READ.
  - READ: issues reads and compares returned words.
  - DRAIN: no new reads; waits for in-flight words to return and be compared.
  - PASS, FAIL: terminal states. Outputs hold until the next start.
- fifo_rd_en is combinational: (state==READ) && !fifo_empty && (issued < NDATA). It is never asserted while fifo_empty=1.
- Each sampled read pushes a valid bit into an RD_LAT-deep pipe. When the valid bit reaches the pipe output, fifo_q is compared with (BASE + rcv_cnt)[7:0], then rcv_cnt increments.
- Mismatch handling:
  - On the first mismatch, capture err_idx=rcv_cnt and err_data=fifo_q, then go to FAIL.
  - Reads stop in the same cycle. In-flight words are discarded and not compared.
- issued==NDATA moves READ to DRAIN. The last compare in DRAIN goes to PASS if every word matched.
- Reset values: fifo_rd_en, busy, pass, fail and timeout are 0. All counters, err_idx and err_data are 0. state=IDLE. led_r_n, led_g_n and led_b_n are 1 (all LEDs off).
- busy=1 in READ and DRAIN only.

## Timing
- Read latency: fifo_rd_en sampled high at edge t gives fifo_q valid at edge t+RD_LAT.
- start is accepted in IDLE, PASS or FAIL, and is ignored while busy. The first fifo_rd_en can occur in the second cycle after the start edge.
- Boundary conditions:
  - Empty mid-run: reads pause and the run resumes when Empty falls. Nothing is counted twice and nothing is skipped.
  - Mismatch on the final word: gives FAIL, not PASS.
  - Counter widths: rcv_cnt and issued are 11 bits. Pattern arithmetic wraps modulo 256 (word 191 with BASE=65 expects 0x00).
- Reset asserted mid-run: fifo_rd_en drops asynchronously. The FIFO contents are not the block's responsibility.

## Configuration
- CHK_TIMEOUT_EN defined:
  - An idle counter increments each READ/DRAIN cycle in which no compare happens, and clears on every compare.
  - Reaching TIMEOUT gives FAIL with timeout=1 and err_idx=rcv_cnt.
- CHK_TIMEOUT_EN undefined: no counter is built. A stalled FIFO leaves the block in READ indefinitely, and timeout is tied to 0.

## Structure
- Shared package fifo_test_pkg holds:
  - the state encoding (IDLE, READ, DRAIN, PASS, FAIL)
  - CNT_W=11
  - PATTERN_BASE=8'd65
  - the default NDATA=18
- The writer-side generator uses the same package so both ends agree on the pattern.
- One sub-module, rd_valid_pipe: an RD_LAT-deep valid shift register with asynchronous active-low reset and a flush input, asserted on entry to FAIL.

## Test plan
- Preload "A".."R" (65..82), pulse start → 18 compares; pass=1, fail=0, rcv_cnt=18, led_g_n=0, led_b_n=1.
- Preload 65..82 with word 7 corrupted to 0x00 → fail=1, err_idx=7, err_data=0x00, rcv_cnt=7. fifo_rd_en stays 0 after FAIL.
- Toggle Empty every 3 cycles while streaming 65..82 → pass=1. fifo_rd_en is never high while fifo_empty=1.
- NDATA=200, BASE=65 → word 191 expects 0x00; a correctly wrapped stream passes.
- Assert RESET_N low mid-run after 5 words → all outputs reach reset values immediately. A later start with a fresh 65..82 load passes.
- With CHK_TIMEOUT_EN and TIMEOUT=16, supply only 4 words → fail=1, timeout=1, err_idx=4, exactly 16 idle cycles after the last compare.

Source files
------------

// File: rtl/fifo_test_pkg.sv
// -----------------------------------------------------------------------------
// fifo_test_pkg
// Definitions shared by both ends of the FIFO loopback test: the writer-side
// generator and the read-side checker. Keeping them in one place guarantees
// that both sides use the same incrementing pattern.
//   CNT_W         : width of the word counters (11 bits, up to 2047 words)
//   PATTERN_BASE  : first pattern word (ASCII 'A')
//   DEFAULT_NDATA : default number of words per run
//   state_t       : checker FSM state encoding
//   pattern_word  : expected byte for a given word index
// -----------------------------------------------------------------------------
package fifo_test_pkg;

    localparam int         CNT_W         = 11;
    localparam logic [7:0] PATTERN_BASE  = 8'd65;
    localparam int         DEFAULT_NDATA = 18;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        PASS  = 3'd3,
        FAIL  = 3'd4
    } state_t;

    // Word k of a run is (base + k) mod 256. Only the low byte of the index
    // matters, so the add wraps naturally in 8 bits.
    function automatic logic [7:0] pattern_word(input logic [7:0]       base,
                                                input logic [CNT_W-1:0] idx);
        return base + idx[7:0];
    endfunction

endpackage

// File: rtl/fifo_pattern_checker_rd_valid_pipe.sv
// -----------------------------------------------------------------------------
// rd_valid_pipe
// DEPTH-stage shift register that tracks which cycles carry valid FIFO read
// data. A bit enters when a read is sampled and leaves DEPTH edges later,
// which is when fifo_q holds the word that read returned.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : clears every in-flight bit on the next edge
//   in_vld     : a read is being sampled this cycle
//   out_vld    : fifo_q holds a returned word this cycle
// -----------------------------------------------------------------------------
module rd_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_vld,
    output logic out_vld
);

    logic [DEPTH:1] vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_vld;
            for (int i = 2; i <= DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[DEPTH];

endmodule

// File: rtl/fifo_pattern_checker.sv
// -----------------------------------------------------------------------------
// fifo_pattern_checker
// Read side of the FIFO loopback test. On start it drains NDATA words from the
// FIFO, checks each against the incrementing pattern BASE, BASE+1, ... (mod
// 256) and latches pass/fail plus first-error diagnostics until the next start.
//
// Optional feature: define CHK_TIMEOUT_EN to build an idle watchdog. A run
// that sees TIMEOUT consecutive cycles without a compare then fails with
// timeout=1. Without it, a stalled FIFO simply leaves the block busy.
//
// Ports:
//   CLOCK, RESET_N     : FIFO read clock, asynchronous active-low reset
//   start              : one-cycle pulse, accepted when not busy
//   fifo_empty, fifo_q : FIFO Empty flag and read data
//   fifo_rd_en         : FIFO read enable (combinational)
//   busy, pass, fail   : run status; pass/fail are sticky until next start
//   timeout            : the failure was a watchdog expiry
//   rcv_cnt            : words compared so far
//   err_idx, err_data  : index and data of the first failing word
//   led_r_n/g_n/b_n    : active-low LEDs showing fail / pass / busy
// -----------------------------------------------------------------------------
module fifo_pattern_checker
    import fifo_test_pkg::*;
#(
    parameter int NDATA   = DEFAULT_NDATA,
    parameter int BASE    = int'(PATTERN_BASE),
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             start,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_q,
    output logic             fifo_rd_en,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] rcv_cnt,
    output logic [CNT_W-1:0] err_idx,
    output logic [7:0]       err_data,
    output logic             led_r_n,
    output logic             led_g_n,
    output logic             led_b_n
);

    localparam logic [CNT_W-1:0] NDATA_C = CNT_W'(NDATA);
    localparam logic [7:0]       BASE_C  = 8'(BASE);

    state_t           state;
    logic [CNT_W-1:0] issued;
    logic             running;
    logic             data_vld;
    logic             cmp;
    logic             mismatch;
    logic             to_hit;
    logic             flush;

    assign running  = (state == READ) || (state == DRAIN);
    assign cmp      = running && data_vld;
    assign mismatch = cmp && (fifo_q != pattern_word(BASE_C, rcv_cnt));

    // Reads stop in the very cycle a run fails, so no extra word is popped
    // from the FIFO on the way into FAIL.
    assign fifo_rd_en = (state == READ) && !fifo_empty && (issued < NDATA_C)
                        && !mismatch && !to_hit;

    // Anything still in flight when the run fails is discarded uncompared.
    assign flush = mismatch || to_hit;

    rd_valid_pipe #(
        .DEPTH (RD_LAT)
    ) u_vld_pipe (
        .clk     (CLOCK),
        .rst_n   (RESET_N),
        .flush   (flush),
        .in_vld  (fifo_rd_en),
        .out_vld (data_vld)
    );

`ifdef CHK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Counts consecutive running cycles without a compare.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            idle_cnt <= '0;
        end else if (!running || cmp) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th idle cycle.
    assign to_hit = running && !cmp && (idle_cnt == IDLE_W'(TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            busy     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            timeout  <= 1'b0;
            issued   <= '0;
            rcv_cnt  <= '0;
            err_idx  <= '0;
            err_data <= '0;
        end else begin
            case (state)
                IDLE, PASS, FAIL: begin
                    if (start) begin
                        state    <= READ;
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                        fail     <= 1'b0;
                        timeout  <= 1'b0;
                        issued   <= '0;
                        rcv_cnt  <= '0;
                        err_idx  <= '0;
                        err_data <= '0;
                    end
                end

                READ, DRAIN: begin
                    if (fifo_rd_en) begin
                        issued <= issued + 1'b1;
                        // Last read issued: stop reading, wait for returns.
                        if (issued == NDATA_C - 1'b1) begin
                            state <= DRAIN;
                        end
                    end

                    if (mismatch) begin
                        state    <= FAIL;
                        busy     <= 1'b0;
                        fail     <= 1'b1;
                        err_idx  <= rcv_cnt;
                        err_data <= fifo_q;
                    end else if (to_hit) begin
                        state    <= FAIL;
                        busy     <= 1'b0;
                        fail     <= 1'b1;
                        timeout  <= 1'b1;
                        err_idx  <= rcv_cnt;
                    end else if (cmp) begin
                        rcv_cnt <= rcv_cnt + 1'b1;
                        if (rcv_cnt == NDATA_C - 1'b1) begin
                            state <= PASS;
                            busy  <= 1'b0;
                            pass  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign led_r_n = !fail;
    assign led_g_n = !pass;
    assign led_b_n = !busy;

endmodule
